dlsc_fifo_rvh: RTL

Single-clock ready/valid FIFO, 2**ADDR entries deep, that buffers the output of the domain-crossing ready/valid stage before it reaches the consumer. It absorbs bursts and decouples the crossing's `out_ready` from consumer stalls. It provides registered `in_ready`/`out_valid`, an occupancy count, and almost-full/almost-empty flags for upstream throttling and downstream scheduling.

---
 rtl/dlsc_fifo_rvh.sv | 120 ++++++++++++
 1 files changed

// File: rtl/dlsc_fifo_rvh.sv
// Ready/valid FIFO, first-word fall-through, DEPTH = 2**ADDR words total.
// Latency: a word pushed into an empty FIFO is visible on out_data one edge later.
// Backpressure: in_ready is registered. It drops once the FIFO is full and is
// independent of out_ready within a cycle.
//
// Ports:
//   clk, rst              - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     - write handshake; in_data is taken when both are high
//   out_valid/out_ready   - read handshake; out_data is the registered head word
//   count                 - words held, including the output register (0..DEPTH)
//   almost_full/_empty    - registered thresholds on count
module dlsc_fifo_rvh #(
    parameter int              DATA         = 32,
    parameter int              ADDR         = 4,
    parameter int              ALMOST_FULL  = (2**ADDR)-1,
    parameter int              ALMOST_EMPTY = 1,
    parameter logic [DATA-1:0] RESET        = {DATA{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    output logic            in_ready,
    input  logic            in_valid,
    input  logic [DATA-1:0] in_data,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [DATA-1:0] out_data,
    output logic [ADDR:0]   count,
    output logic            almost_full,
    output logic            almost_empty
);

    localparam int DEPTH = 2**ADDR;

    logic [DATA-1:0] mem_q [DEPTH];

    logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR:0]   count_q,  count_d;
    logic [DATA-1:0] out_data_q, out_data_d;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            almost_full_q;
    logic            almost_empty_q;

    logic push, pop;
    logic mem_empty;
    logic load_out;
    logic mem_rd, mem_wr, bypass;

    always_comb begin
        push      = in_ready_q & in_valid;
        pop       = out_valid_q & out_ready;

        // The output register is always filled whenever anything is held,
        // so the memory holds at most DEPTH-1 words. Pointer equality
        // therefore means empty and never full.
        mem_empty = (wr_ptr_q == rd_ptr_q);

        // The output register can take a new word when it is empty or
        // its current word leaves on this edge.
        load_out  = !out_valid_q || pop;
        mem_rd    = load_out && !mem_empty;

        // When the memory is empty, an incoming word goes straight into the
        // output register. This gives the one-edge fill latency and keeps
        // count at 1 while streaming.
        bypass    = load_out && mem_empty && push;
        mem_wr    = push && !bypass;

        wr_ptr_d  = mem_wr ? wr_ptr_q + ADDR'(1) : wr_ptr_q;
        rd_ptr_d  = mem_rd ? rd_ptr_q + ADDR'(1) : rd_ptr_q;

        out_data_d = out_data_q;
        if (mem_rd) begin
            out_data_d = mem_q[rd_ptr_q];
        end else if (bypass) begin
            out_data_d = in_data;
        end

        count_d = count_q + {{ADDR{1'b0}}, push} - {{ADDR{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            out_data_q     <= RESET;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            almost_full_q  <= (ALMOST_FULL == 0);
            almost_empty_q <= 1'b1;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            out_data_q     <= out_data_d;
            in_ready_q     <= (int'(count_d) < DEPTH);
            out_valid_q    <= (count_d != '0);
            almost_full_q  <= (int'(count_d) >= ALMOST_FULL);
            almost_empty_q <= (int'(count_d) <= ALMOST_EMPTY);
        end
    end

    // Storage array: no reset, because the contents are only meaningful
    // between the pointers.
    always_ff @(posedge clk) begin
        if (mem_wr && !rst) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign count        = count_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;

endmodule
